// File: rtl/pong_ball_motion.sv
// Frame-rate ball physics for the pong demo. On each rising edge of vertical
// sync the ball centre moves one step. It bounces off the top, bottom and right
// walls and off the paddle. A miss on the left returns the ball to screen centre,
// where it is held for a serve delay before it moves again.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_SERVE | ball held at centre, counting frame ticks up to the serve delay
// ST_MOVE  | ball advances one step per frame tick, with wall and paddle bounces
module pong_ball_motion #(
  parameter int GRAPHICS_WIDTH     = 1280,
  parameter int GRAPHICS_HEIGHT    = 800,
  parameter int BORDER_WIDTH       = 50,
  parameter int BALL_RADIUS        = 10,
  parameter int BALL_SPEED_X       = 4,
  parameter int BALL_SPEED_Y       = 3,
  parameter int PADDLE_WIDTH       = 20,
  parameter int PADDLE_LENGTH      = 200,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POSITION_REG_MAX   = 11
) (
  input  logic                      pixel_clock,
  input  logic                      reset,
  input  logic                      vga_vertical_sync,
  input  logic [POSITION_REG_MAX:0] paddle_x,
  input  logic [POSITION_REG_MAX:0] paddle_y,
  output logic [POSITION_REG_MAX:0] ball_x,
  output logic [POSITION_REG_MAX:0] ball_y,
  output logic                      serving,
  output logic                      miss_pulse
);

  localparam int W     = POSITION_REG_MAX + 1;
  localparam int SW    = W + 1;
  localparam int CNT_W = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;

  localparam logic [W-1:0]     X_CENTRE  = W'(GRAPHICS_WIDTH / 2);
  localparam logic [W-1:0]     Y_CENTRE  = W'(GRAPHICS_HEIGHT / 2);
  localparam logic [SW-1:0]    Y_TOP     = SW'(BORDER_WIDTH + BALL_RADIUS);
  localparam logic [SW-1:0]    Y_BOTTOM  = SW'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS);
  localparam logic [SW-1:0]    X_RIGHT   = SW'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS);
  localparam logic [SW-1:0]    X_MISS    = SW'(BORDER_WIDTH + BALL_RADIUS + BALL_SPEED_X);
  localparam logic [SW-1:0]    SPD_X     = SW'(BALL_SPEED_X);
  localparam logic [SW-1:0]    SPD_Y     = SW'(BALL_SPEED_Y);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_DELAY_FRAMES - 1);

  typedef enum logic {ST_SERVE, ST_MOVE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_nxt;
  logic [W-1:0]     ball_x_nxt, ball_y_nxt;
  logic             dir_right, dir_right_nxt;
  logic             dir_down, dir_down_nxt;
  logic             serving_nxt, miss_nxt;
  logic             last_vsync;
  logic             tick;

  // Widened copies so every bound check is an addition that cannot wrap.
  logic [SW-1:0] bx_w, by_w, px_w, py_w;
  logic [SW-1:0] x_plus, x_minus, y_plus, y_minus;
  logic          paddle_hit;

  assign tick = vga_vertical_sync & ~last_vsync;

  assign bx_w    = {1'b0, ball_x};
  assign by_w    = {1'b0, ball_y};
  assign px_w    = {1'b0, paddle_x};
  assign py_w    = {1'b0, paddle_y};
  assign x_plus  = bx_w + SPD_X;
  assign x_minus = bx_w - SPD_X;
  assign y_plus  = by_w + SPD_Y;
  assign y_minus = by_w - SPD_Y;

  assign paddle_hit = (bx_w < px_w + SW'(PADDLE_WIDTH + BALL_RADIUS + BALL_SPEED_X)) &&
                      (bx_w >= px_w + SW'(BALL_RADIUS)) &&
                      (py_w <= by_w) &&
                      (by_w <= py_w + SW'(PADDLE_LENGTH));

  // State and position registers; reset returns the ball to centre in serve.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state      <= ST_SERVE;
      serve_cnt  <= '0;
      ball_x     <= X_CENTRE;
      ball_y     <= Y_CENTRE;
      dir_right  <= 1'b1;
      dir_down   <= 1'b0;
      serving    <= 1'b1;
      miss_pulse <= 1'b0;
      last_vsync <= 1'b0;
    end else begin
      state      <= state_nxt;
      serve_cnt  <= serve_cnt_nxt;
      ball_x     <= ball_x_nxt;
      ball_y     <= ball_y_nxt;
      dir_right  <= dir_right_nxt;
      dir_down   <= dir_down_nxt;
      serving    <= serving_nxt;
      miss_pulse <= miss_nxt;
      last_vsync <= vga_vertical_sync;
    end
  end

  // Per-tick serve countdown and ball physics; nothing changes between ticks.
  always_comb begin
    state_nxt     = state;
    serve_cnt_nxt = serve_cnt;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    dir_right_nxt = dir_right;
    dir_down_nxt  = dir_down;
    serving_nxt   = serving;
    miss_nxt      = 1'b0;

    if (tick) begin
      case (state)
        ST_SERVE: begin
          if (serve_cnt == CNT_LAST) begin
            state_nxt     = ST_MOVE;
            serving_nxt   = 1'b0;
            serve_cnt_nxt = '0;
          end else begin
            serve_cnt_nxt = serve_cnt + CNT_W'(1);
          end
        end

        ST_MOVE: begin
          if (dir_down) begin
            if (y_plus > Y_BOTTOM) begin
              ball_y_nxt   = Y_BOTTOM[W-1:0];
              dir_down_nxt = 1'b0;
            end else begin
              ball_y_nxt = y_plus[W-1:0];
            end
          end else begin
            if (by_w < Y_TOP + SPD_Y) begin
              ball_y_nxt   = Y_TOP[W-1:0];
              dir_down_nxt = 1'b1;
            end else begin
              ball_y_nxt = y_minus[W-1:0];
            end
          end

          if (dir_right) begin
            if (x_plus > X_RIGHT) begin
              ball_x_nxt    = X_RIGHT[W-1:0];
              dir_right_nxt = 1'b0;
            end else begin
              ball_x_nxt = x_plus[W-1:0];
            end
          end else if (paddle_hit) begin
            ball_x_nxt    = paddle_x + W'(PADDLE_WIDTH + BALL_RADIUS);
            dir_right_nxt = 1'b1;
          end else if (bx_w < X_MISS) begin
            // The miss discards this tick's y step and flips y relative to
            // the direction held before the tick.
            miss_nxt      = 1'b1;
            state_nxt     = ST_SERVE;
            serving_nxt   = 1'b1;
            serve_cnt_nxt = '0;
            ball_x_nxt    = X_CENTRE;
            ball_y_nxt    = Y_CENTRE;
            dir_right_nxt = 1'b1;
            dir_down_nxt  = ~dir_down;
          end else begin
            ball_x_nxt = x_minus[W-1:0];
          end
        end

        default: state_nxt = ST_SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_motion.sv
// Directed bench for pong_ball_motion: follows the ball along hand-computed
// trajectories through serve, wall bounces, a miss, a paddle hit and a reset.
module tb_pong_ball_motion;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b0;
  logic        vga_vertical_sync = 1'b0;
  logic [11:0] paddle_x = 12'd110;
  logic [11:0] paddle_y = 12'd110;
  logic [11:0] ball_x, ball_y;
  logic        serving, miss_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  pong_ball_motion dut (
    .pixel_clock       (pixel_clock),
    .reset             (reset),
    .vga_vertical_sync (vga_vertical_sync),
    .paddle_x          (paddle_x),
    .paddle_y          (paddle_y),
    .ball_x            (ball_x),
    .ball_y            (ball_y),
    .serving           (serving),
    .miss_pulse        (miss_pulse)
  );

  always #5 pixel_clock = ~pixel_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, " x"}, 32'(ball_x), ex);
    check({tag, " y"}, 32'(ball_y), ey);
  endtask

  // One frame tick: vsync high for one cycle, then low. Outputs are sampled
  // at the falling edge after the updating rising edge.
  task automatic tick();
    @(negedge pixel_clock) vga_vertical_sync = 1'b1;
    @(negedge pixel_clock) vga_vertical_sync = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset
    @(negedge pixel_clock) reset = 1'b1;
    @(negedge pixel_clock);
    @(negedge pixel_clock) reset = 1'b0;
    check_pos("reset", 640, 400);
    check("reset serving", 32'(serving), 1);
    check("reset miss", 32'(miss_pulse), 0);

    // Serve delay
    run_ticks(59);
    check("serve59 serving", 32'(serving), 1);
    check_pos("serve59", 640, 400);
    tick();
    check("serve60 serving", 32'(serving), 0);
    check_pos("serve60", 640, 400);
    repeat (5) @(negedge pixel_clock);
    check_pos("idle", 640, 400);
    tick();
    check_pos("move1", 644, 397);

    // Top wall: y 61 -> 60 (reflect) -> 63
    run_ticks(112);
    check_pos("k113", 1092, 61);
    tick();
    check("k114 y", 32'(ball_y), 60);
    tick();
    check_pos("k115", 1100, 63);

    // Right wall: x 1216 -> 1220 -> 1220 (reflect) -> 1216
    run_ticks(29);
    check("k144 x", 32'(ball_x), 1216);
    tick();
    check("k145 x", 32'(ball_x), 1220);
    tick();
    check_pos("k146", 1220, 156);
    tick();
    check("k147 x", 32'(ball_x), 1216);

    // Bottom wall: y 738 -> 740 (reflect) -> 737
    run_ticks(194);
    check_pos("k341", 440, 740);
    tick();
    check_pos("k342", 436, 737);

    // Left miss with ball y outside the paddle span 110..310
    run_ticks(94);
    check_pos("k436", 60, 455);
    check("k436 miss", 32'(miss_pulse), 0);
    tick();
    check("miss pulse", 32'(miss_pulse), 1);
    check_pos("miss", 640, 400);
    check("miss serving", 32'(serving), 1);
    @(negedge pixel_clock);
    check("miss pulse width", 32'(miss_pulse), 0);
    run_ticks(59);
    check("reserve59 serving", 32'(serving), 1);
    check_pos("reserve59", 640, 400);
    tick();
    check("reserve60 serving", 32'(serving), 0);
    tick();
    check_pos("reserve move1", 644, 403);

    // Paddle hit at paddle (110,110), ball (140,285) moving left
    run_ticks(415);
    check_pos("r2 k416", 140, 285);
    tick();
    check_pos("hit", 140, 288);
    check("hit miss", 32'(miss_pulse), 0);
    tick();
    check_pos("after hit", 144, 291);

    // Reset coinciding with a tick in MOVE
    @(negedge pixel_clock) begin
      vga_vertical_sync = 1'b1;
      reset = 1'b1;
    end
    @(negedge pixel_clock) begin
      vga_vertical_sync = 1'b0;
      reset = 1'b0;
    end
    check_pos("reset on tick", 640, 400);
    check("reset on tick serving", 32'(serving), 1);
    check("reset on tick miss", 32'(miss_pulse), 0);
    run_ticks(59);
    check("post reset 59 serving", 32'(serving), 1);
    tick();
    check("post reset 60 serving", 32'(serving), 0);
    check_pos("post reset 60", 640, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_ball_motion.md
Name: pong_ball_motion

Overview:
Frame-rate ball physics stage for the pong demo. It sits directly upstream of the pixel renderer and supplies the ball_x/ball_y centre that the renderer compares against h_position/v_position. Once per frame, on the rising edge of vertical sync, it advances the ball. It reflects the ball off the top, bottom and right border walls and off the player paddle. It detects a miss on the left side and re-serves the ball from screen centre after a delay.

Parameters:
GRAPHICS_WIDTH, 1280, visible width in pixels
GRAPHICS_HEIGHT, 800, visible height in pixels
BORDER_WIDTH, 50, border thickness on all four sides
BALL_RADIUS, 10, ball radius in pixels
BALL_SPEED_X, 4, horizontal step per frame
BALL_SPEED_Y, 3, vertical step per frame
PADDLE_WIDTH, 20, paddle extent in x
PADDLE_LENGTH, 200, paddle extent in y
SERVE_DELAY_FRAMES, 60, frames the ball is held at centre before moving
POSITION_REG_MAX, 11, MSB index of all position buses

Ports:
pixel_clock  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
vga_vertical_sync  in  1  sync output of the vga timing block; its rising edge is the frame tick
paddle_x  in  POSITION_REG_MAX+1  paddle left edge
paddle_y  in  POSITION_REG_MAX+1  paddle top edge
ball_x  out  POSITION_REG_MAX+1  ball centre x, registered
ball_y  out  POSITION_REG_MAX+1  ball centre y, registered
serving  out  1  high while the ball is held at centre
miss_pulse  out  1  one-cycle pulse when the ball passes the paddle

Behaviour:
- Reset values:
  - ball_x = GRAPHICS_WIDTH/2 (640), ball_y = GRAPHICS_HEIGHT/2 (400).
  - State SERVE, serving = 1, serve counter = 0, miss_pulse = 0, last_vsync = 0.
  - dir_x = right, dir_y = up.
- Reset mid-operation: all state returns to the reset values at the next edge. A tick coinciding with reset is ignored.
- Tick: tick = vga_vertical_sync & ~last_vsync. last_vsync is registered every cycle. All position and state updates occur on the edge ending the tick cycle, so the latency is one cycle. No updates occur between ticks.
- State SERVE:
  - Each tick increments the counter.
  - On the tick where counter == SERVE_DELAY_FRAMES-1: go to MOVE, clear serving, clear the counter. Position does not change on this tick.
- State MOVE, per tick, with each axis evaluated independently:
  - Y, moving up: if ball_y < BORDER_WIDTH+BALL_RADIUS+BALL_SPEED_Y, then ball_y <= BORDER_WIDTH+BALL_RADIUS and dir_y <= down. Otherwise ball_y -= BALL_SPEED_Y.
  - Y, moving down: if ball_y + BALL_SPEED_Y > GRAPHICS_HEIGHT-BORDER_WIDTH-BALL_RADIUS, then clamp to that limit and set dir_y <= up. Otherwise ball_y += BALL_SPEED_Y.
  - X, moving right: if ball_x + BALL_SPEED_X > GRAPHICS_WIDTH-BORDER_WIDTH-BALL_RADIUS (1220), then ball_x <= 1220 and dir_x <= left. Otherwise ball_x += BALL_SPEED_X.
  - X, moving left, paddle hit when all of the following hold:
    - ball_x < paddle_x+PADDLE_WIDTH+BALL_RADIUS+BALL_SPEED_X
    - ball_x >= paddle_x+BALL_RADIUS
    - paddle_y <= ball_y <= paddle_y+PADDLE_LENGTH
    - Then ball_x <= paddle_x+PADDLE_WIDTH+BALL_RADIUS and dir_x <= right.
  - X, moving left, miss when there is no paddle hit and ball_x < BORDER_WIDTH+BALL_RADIUS+BALL_SPEED_X:
    - miss_pulse = 1 for exactly one cycle.
    - Ball returns to centre, state SERVE, serving = 1, dir_x = right.
    - dir_y toggles relative to its value at the miss.
    - The y update computed for this tick is discarded.
  - X, moving left, otherwise: ball_x -= BALL_SPEED_X.
- Simultaneous events:
  - A corner hit reflects both axes on the same tick.
  - A paddle hit takes priority over a miss.
  - A miss overrides any y reflection on that tick.
- Arithmetic: all comparisons are unsigned and are written in additive form so that no subtraction can underflow. The sum paths are one bit wider than the position buses.
- Paddle inputs are sampled only on the tick cycle. Paddle values changing between ticks have no effect.

Test Plan:
- Reset, then 60 vsync rising edges:
  - Before the 60th tick: serving = 1, ball stays (640,400).
  - After the 60th tick: serving = 0, ball still (640,400).
  - After the 61st tick: ball = (644,397).
- Ball forced to y=62 moving up, x mid-field:
  - Next tick: y = 60, dir down.
  - Following tick: y = 63.
- Ball at x=1218 moving right: next tick x = 1220; following tick x = 1216.
- paddle_x=110, paddle_y=110, ball (142,200) moving left: next tick x = 140, dir right; following tick x = 144.
- Same paddle, ball (62,400) moving left with y outside 110..310:
  - Next tick: miss_pulse high for 1 cycle, ball = (640,400), serving = 1, dir_y toggled.
  - The following 59 ticks hold position.
- Reset asserted in a MOVE frame on the cycle of a tick: ball = (640,400), serving = 1, miss_pulse = 0, and the tick is ignored.
